// File: rtl/cdc_4phase_src.sv
// Source end of a 4-phase req/ack CDC handshake.
// Flop-only req/data toward the destination; ack is synchronized locally.
module cdc_4phase_src #(
    parameter int DataWidth  = 32,
    parameter int SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 async_req_o,
    input  logic                 async_ack_i,
    output logic [DataWidth-1:0] async_data_o
);

    if (SyncStages < 2) begin : g_bad_sync
        $error("cdc_4phase_src: SyncStages must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   req_q, req_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [SyncStages-1:0]  sync_q;
    logic                   ack_s;

    assign ack_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], async_ack_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        req_d   = req_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                // ready is low only for the first cycle after reset
                if (!ready_q) begin
                    ready_d = 1'b1;
                end else if (valid_i) begin
                    data_d  = data_i;
                    req_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_ACK_LO;
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_s) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign ready_o      = ready_q;
    assign async_req_o  = req_q;
    assign async_data_o = data_q;

endmodule
